// File: rtl/hazard_pkg.sv
// Shared constants and the register-match helper for the MIPS hazard unit.
package hazard_pkg;

  localparam int unsigned REG_AW_MAX = 8;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

  // True when a live write to dest targets addr; register 0 never matches.
  function automatic logic reg_match(input logic [REG_AW_MAX-1:0] addr,
                                     input logic [REG_AW_MAX-1:0] dest,
                                     input logic                  we);
    return we && (dest != REG_ZERO) && (dest == addr);
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Busy scoreboard for the multi-cycle multiply/divide unit: MdBusy is high
// for exactly MDU_LAT cycles after each MdStartE (a reissue reloads).
module mdu_scoreboard #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MdStartE,
  output logic MdBusy
);

  localparam int unsigned CW = $clog2(MDU_LAT + 1);

  logic [CW-1:0] md_cnt;
  logic [CW-1:0] md_cnt_next;

  always_comb begin
    md_cnt_next = md_cnt;
    if (MdStartE) begin
      md_cnt_next = CW'(MDU_LAT);
    end else if (md_cnt != '0) begin
      md_cnt_next = md_cnt - CW'(1);
    end
  end

  // Busy flag kept in its own flop so it is a clean registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
      MdBusy <= 1'b0;
    end else begin
      md_cnt <= md_cnt_next;
      MdBusy <= (md_cnt_next != '0);
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Combined EX/ID forwarding and stall detection for the 5-stage MIPS pipe,
// with optional MDU busy tracking (enabled by HAZARD_MDU_EN).
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MdStartD,
  input  logic              MdStartE,
  input  logic              MfHiLoD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCount
);

  logic [REG_AW_MAX-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic lwstall, brstall, mdstall, stall;
  logic e_hits_d, m_hits_d;

  assign rs_d = REG_AW_MAX'(RsD);
  assign rt_d = REG_AW_MAX'(RtD);
  assign rs_e = REG_AW_MAX'(RsE);
  assign rt_e = REG_AW_MAX'(RtE);
  assign wr_e = REG_AW_MAX'(WriteRegE);
  assign wr_m = REG_AW_MAX'(WriteRegM);
  assign wr_w = REG_AW_MAX'(WriteRegW);

  // Forwarding selects; M stage wins over W.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reg_match(rs_e, wr_m, RegWriteM))      ForwardAE = FWD_M;
    else if (reg_match(rs_e, wr_w, RegWriteW)) ForwardAE = FWD_W;
    if (reg_match(rt_e, wr_m, RegWriteM))      ForwardBE = FWD_M;
    else if (reg_match(rt_e, wr_w, RegWriteW)) ForwardBE = FWD_W;
    ForwardAD = reg_match(rs_d, wr_m, RegWriteM);
    ForwardBD = reg_match(rt_d, wr_m, RegWriteM);
  end

  // Load-use and branch-compare hazards.
  always_comb begin
    e_hits_d = reg_match(rs_d, wr_e, RegWriteE) || reg_match(rt_d, wr_e, RegWriteE);
    m_hits_d = reg_match(rs_d, wr_m, MemtoRegM) || reg_match(rt_d, wr_m, MemtoRegM);
    lwstall  = MemtoRegE && e_hits_d;
    brstall  = BranchD && (e_hits_d || m_hits_d);
    stall    = lwstall || brstall || mdstall;
    StallF   = stall;
    StallD   = stall;
    FlushE   = stall;
  end

`ifdef HAZARD_MDU_EN
  mdu_scoreboard #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .MdStartE (MdStartE),
    .MdBusy   (MdBusy)
  );

  assign mdstall = (MfHiLoD || MdStartD) && (MdBusy || MdStartE);
`else
  logic unused_md;

  assign MdBusy    = 1'b0;
  assign mdstall   = 1'b0;
  assign unused_md = &{1'b0, MdStartD, MdStartE, MfHiLoD, MDU_LAT[0]};
`endif

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (stall && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (default and CNT_W=2 copies).
module tb_hazard_unit_mc;

  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic              BranchD, MdStartD, MdStartE, MfHiLoD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;
  logic [15:0]       StallCount;
  logic [1:0]        ForwardAE2, ForwardBE2;
  logic              ForwardAD2, ForwardBD2, StallF2, StallD2, FlushE2, MdBusy2;
  logic [1:0]        StallCount2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(REG_AW), .MDU_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdStartD(MdStartD), .MdStartE(MdStartE), .MfHiLoD(MfHiLoD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );

  hazard_unit_mc #(.REG_AW(REG_AW), .MDU_LAT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdStartD(MdStartD), .MdStartE(MdStartE), .MfHiLoD(MfHiLoD),
    .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2), .ForwardAD(ForwardAD2),
    .ForwardBD(ForwardBD2), .StallF(StallF2), .StallD(StallD2), .FlushE(FlushE2),
    .MdBusy(MdBusy2), .StallCount(StallCount2)
  );

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
    MdStartD = 1'b0; MdStartE = 1'b0; MfHiLoD = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (StallCount !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", StallCount);
    end
    checks++;
    if (MdBusy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", MdBusy);
    end
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL reset_stall: got %b expected 000", {StallF, StallD, FlushE});
    end
  endtask

  task automatic test_ex_forward();
    @(negedge clk);
    clear_inputs();
    RsE = 5'd10; RtE = 5'd10; WriteRegM = 5'd10; WriteRegW = 5'd10;
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      errors++; $display("FAIL fwd_m_prio: got %b expected 1010", {ForwardAE, ForwardBE});
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) begin
      errors++; $display("FAIL fwd_w: got %b expected 0101", {ForwardAE, ForwardBE});
    end
    RegWriteW = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL fwd_rf: got %b expected 0000", {ForwardAE, ForwardBE});
    end
    // Split sources: A from W, B from M.
    RsE = 5'd3; RtE = 5'd4; WriteRegW = 5'd3; WriteRegM = 5'd4;
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0110) begin
      errors++; $display("FAIL fwd_split: got %b expected 0110", {ForwardAE, ForwardBE});
    end
  endtask

  task automatic test_reg_zero();
    @(negedge clk);
    clear_inputs();
    RegWriteE = 1'b1; RegWriteM = 1'b1; RegWriteW = 1'b1;
    MemtoRegE = 1'b1; MemtoRegM = 1'b1; BranchD = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'b0) begin
      errors++; $display("FAIL reg0_fwd: got %b expected 000000",
                         {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
    end
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL reg0_stall: got %b expected 000", {StallF, StallD, FlushE});
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; RtD = 5'd5;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b111) begin
      errors++; $display("FAIL lw_rt: got %b expected 111", {StallF, StallD, FlushE});
    end
    RtD = 5'd6;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL lw_nomatch: got %b expected 000", {StallF, StallD, FlushE});
    end
    RsD = 5'd5;
    #1;
    checks++;
    if (StallD !== 1'b1) begin
      errors++; $display("FAIL lw_rs: got %b expected 1", StallD);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    BranchD = 1'b1; RsD = 5'd7; RegWriteE = 1'b1; WriteRegE = 5'd7;
    #1;
    checks++;
    if (StallF !== 1'b1) begin
      errors++; $display("FAIL br_e: got %b expected 1", StallF);
    end
    RegWriteE = 1'b0; MemtoRegM = 1'b1; WriteRegM = 5'd7;
    #1;
    checks++;
    if (StallF !== 1'b1) begin
      errors++; $display("FAIL br_m_load: got %b expected 1", StallF);
    end
    MemtoRegM = 1'b0; RegWriteM = 1'b1;
    #1;
    checks++;
    if ({StallF, ForwardAD, ForwardBD} !== 3'b010) begin
      errors++; $display("FAIL br_fwd_ad: got %b expected 010", {StallF, ForwardAD, ForwardBD});
    end
    RsD = 5'd1; RtD = 5'd7;
    #1;
    checks++;
    if ({ForwardAD, ForwardBD} !== 2'b01) begin
      errors++; $display("FAIL br_fwd_bd: got %b expected 01", {ForwardAD, ForwardBD});
    end
    BranchD = 1'b0; RegWriteE = 1'b1; WriteRegE = 5'd7;
    #1;
    checks++;
    if (StallF !== 1'b0) begin
      errors++; $display("FAIL nobranch_alu: got %b expected 0", StallF);
    end
  endtask

  task automatic test_mdu();
    logic exp_busy;
    do_reset();
`ifdef HAZARD_MDU_EN
    MdStartE = 1'b1; MfHiLoD = 1'b1;
    #1;
    checks++;
    if ({MdBusy, StallF} !== 2'b01) begin
      errors++; $display("FAIL mdu_c0: got %b expected 01", {MdBusy, StallF});
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      MdStartE = 1'b0;
      #1;
      exp_busy = (c <= 4);
      checks++;
      if ({MdBusy, StallF} !== {exp_busy, exp_busy}) begin
        errors++; $display("FAIL mdu_c%0d: got %b expected %b", c, {MdBusy, StallF},
                           {exp_busy, exp_busy});
      end
    end
    do_reset();
    MdStartE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (MdBusy !== 1'b1) begin
      errors++; $display("FAIL mdu_rst_c2: got %b expected 1", MdBusy);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (MdBusy !== 1'b0) begin
      errors++; $display("FAIL mdu_rst_c3: got %b expected 0", MdBusy);
    end
`else
    MdStartE = 1'b1; MdStartD = 1'b1; MfHiLoD = 1'b1;
    #1;
    checks++;
    if (StallF !== 1'b0) begin
      errors++; $display("FAIL mdu_off_stall: got %b expected 0", StallF);
    end
    @(negedge clk);
    exp_busy = 1'b0;
    checks++;
    if (MdBusy !== exp_busy) begin
      errors++; $display("FAIL mdu_off_busy: got %b expected 0", MdBusy);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_counter();
    do_reset();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RsD = 5'd9;
    repeat (3) @(negedge clk);
    checks++;
    if (StallCount !== 16'd3 || StallCount2 !== 2'd3) begin
      errors++; $display("FAIL cnt_3: got %0d/%0d expected 3/3", StallCount, StallCount2);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (StallCount !== 16'd5 || StallCount2 !== 2'd3) begin
      errors++; $display("FAIL cnt_sat: got %0d/%0d expected 5/3", StallCount, StallCount2);
    end
    RsD = 5'd8;
    repeat (2) @(negedge clk);
    checks++;
    if (StallCount !== 16'd5) begin
      errors++; $display("FAIL cnt_hold: got %0d expected 5", StallCount);
    end
    do_reset();
    checks++;
    if (StallCount !== 16'd0 || StallCount2 !== 2'd0) begin
      errors++; $display("FAIL cnt_clear: got %0d/%0d expected 0/0", StallCount, StallCount2);
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_reg_zero();
    test_load_use();
    test_branch();
    test_mdu();
    test_counter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard unit for the 5-stage MIPS pipeline, replacing the separate EX-stage and ID-branch forwarding blocks with one unit. It generates EX-stage and ID-stage forwarding selects and detects load-use and branch-compare stalls. It also tracks a multi-cycle multiply/divide unit (MDU) with a busy scoreboard, and keeps a saturating stall-cycle counter. It sits beside the datapath, between the pipeline registers and the stall/flush controls of the F, D and E stages.

## Interface
- REG_AW, 5: register-address width.
- MDU_LAT, 4: MDU busy cycles after issue, ≥1.
- CNT_W, 16: stall-counter width.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- RsD, RtD  in  REG_AW  decode source registers
- RsE, RtE  in  REG_AW  execute source registers
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  writeback enable per stage
- MemtoRegE, MemtoRegM  in  1  load in E / M
- BranchD  in  1  branch compare in decode
- MdStartD, MdStartE  in  1  mult/div in D / issuing in E
- MfHiLoD  in  1  MFHI/MFLO in decode
- ForwardAE, ForwardBE  out  2  EX operand select
- ForwardAD, ForwardBD  out  1  ID compare select (1 = from M)
- StallF, StallD, FlushE  out  1  pipeline control
- MdBusy  out  1  MDU scoreboard busy
- StallCount  out  CNT_W  saturating stall-cycle count

## Operation
- Register 0 never matches any forwarding or stall term.
- ForwardAE: 2'b10 if RegWriteM && WriteRegM==RsE. Otherwise 2'b01 if RegWriteW && WriteRegW==RsE. Otherwise 2'b00. M has priority over W. ForwardBE uses the same rule with RtE.
- ForwardAD = RegWriteM && WriteRegM==RsD. ForwardBD uses the same rule with RtD.
- lwstall = MemtoRegE && RegWriteE && WriteRegE ∈ {RsD, RtD}.
- brstall = BranchD && ((RegWriteE && WriteRegE ∈ {RsD, RtD}) || (MemtoRegM && WriteRegM ∈ {RsD, RtD})).
- mdstall = (MfHiLoD || MdStartD) && (MdBusy || MdStartE).
- stall = lwstall | brstall | mdstall. StallF = StallD = FlushE = stall.
- MDU scoreboard: counter md_cnt, width clog2(MDU_LAT+1).
  - MdStartE loads MDU_LAT.
  - Otherwise a nonzero count decrements by 1.
  - MdBusy = (md_cnt != 0).
  - MdStartE while busy is a pipeline error. The counter reloads and the design is not required to flag it.
- StallCount increments on each cycle with stall=1 and saturates at all-ones.

## Timing
- All forward and stall outputs are combinational from the current inputs, with zero latency.
- MdBusy is registered. It rises the cycle after MdStartE is sampled and stays high exactly MDU_LAT cycles.
- A dependent MFHI/MFLO in D stalls from the MdStartE cycle through the last MdBusy cycle. It proceeds on the first cycle with MdBusy=0.
- Reset: md_cnt=0, MdBusy=0, StallCount=0. Combinational outputs follow their inputs during reset.
- Reset mid-MDU-operation clears the count immediately on the next edge.
- Simultaneous conditions: stall terms OR together. Forwarding is computed regardless of stall.

## Configuration
- HAZARD_MDU_EN:
  - Defined: the MDU scoreboard and mdstall are built as specified.
  - Undefined: md_cnt is absent, MdBusy is tied 0, mdstall=0, and the MdStartD, MdStartE and MfHiLoD inputs are ignored.
  - Forwarding, lwstall, brstall and StallCount are identical in both builds.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - the reg-zero constant
  - a match function (addr, dest, we) that excludes register 0
- One sub-module, mdu_scoreboard (MDU_LAT parameter; clk, reset, MdStartE → MdBusy), instantiated only under HAZARD_MDU_EN.

## Test plan
- EX forwarding priority: RsE=RtE=10, WriteRegM=WriteRegW=10, RegWriteM=RegWriteW=1 → ForwardAE=ForwardBE=2'b10. Then RegWriteM=0 → 2'b01. Then RegWriteW=0 → 2'b00.
- Register 0: all address inputs 0 and all write enables 1 → every Forward output 0 and stall=0.
- Load-use: MemtoRegE=RegWriteE=1, WriteRegE=5, RtD=5 → StallF=StallD=FlushE=1. Changing RtD to 6 → all 0.
- Branch: BranchD=1, RsD=7, RegWriteE=1, WriteRegE=7 → stall=1. Same with MemtoRegM=1, WriteRegM=7 instead → stall=1. With RegWriteM=1 only (no load) → stall=0 and ForwardAD=1.
- MDU (MDU_LAT=4, HAZARD_MDU_EN defined): MdStartE pulse at cycle 0 → MdBusy high for cycles 1–4. MfHiLoD held high → stall=1 for cycles 0–4 and 0 at cycle 5. Reset asserted at cycle 2 → MdBusy=0 from cycle 3.
- Counter: stall held 3 cycles → StallCount=3. With CNT_W=2, stall held 5 cycles → StallCount stays at 3.
